// File: rtl/led_status_ctrl_if.sv
// Status-LED bank bus: per-channel modes and phase clear in,
// LED drive and shared timebase strobe out.
interface led_status_ctrl_if #(
    parameter int N_LED = 5
);
    logic [2*N_LED-1:0] mode;
    logic               phase_clr;
    logic [N_LED-1:0]   led;
    logic               tick;

    modport master (
        output mode,
        output phase_clr,
        input  led,
        input  tick
    );

    modport slave (
        input  mode,
        input  phase_clr,
        output led,
        output tick
    );
endinterface

// File: rtl/led_status_ctrl.sv
// Status-LED driver: off/on/blink/breathe per channel on a shared
// millisecond timebase so every animated channel stays phase-aligned.
module led_status_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int N_LED      = 5,
    parameter int BLINK_MS   = 250,
    parameter int PWM_W      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input logic         clk50M,
    input logic         reset_n,
    led_status_ctrl_if.slave bus
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
    localparam logic [BW-1:0]    BMAX = BW'(BLINK_MS - 1);
    localparam logic [PWM_W-1:0] LMAX = '1;
    localparam logic [PWM_W-1:0] LONE = PWM_W'(1);
    localparam logic             AL   = (ACTIVE_LOW != 0);

    if (DIV < 2) begin : g_div_chk
        $error("led_status_ctrl: CLK_FREQ/TICK_HZ must be >= 2");
    end

    if (BLINK_MS < 1) begin : g_blink_chk
        $error("led_status_ctrl: BLINK_MS must be >= 1");
    end

    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } dir_e;

    logic [PW-1:0]    pcnt;
    logic             tick_q;
    logic [BW-1:0]    bcnt;
    logic             blink_ph;
    logic [PWM_W-1:0] lvl;
    dir_e             dir;
    logic [PWM_W-1:0] pwm;
    logic [N_LED-1:0] lit;
    logic [N_LED-1:0] led_q;

    // Prescaler; tick is the registered wrap of pcnt
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
        end else if (bus.phase_clr) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pcnt == PMAX);
            pcnt   <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            bcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (bus.phase_clr) begin
            bcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (tick_q) begin
            if (bcnt == BMAX) begin
                bcnt     <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Triangle ramp; the turnaround steps away from the end value
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
            dir <= RISE;
        end else if (bus.phase_clr) begin
            lvl <= '0;
            dir <= RISE;
        end else if (tick_q) begin
            unique case (dir)
                RISE: begin
                    if (lvl == LMAX) begin
                        dir <= FALL;
                        lvl <= lvl - 1'b1;
                    end else begin
                        lvl <= lvl + 1'b1;
                    end
                end
                FALL: begin
                    if (lvl == '0) begin
                        dir <= RISE;
                        lvl <= LONE;
                    end else begin
                        lvl <= lvl - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 1'b1;
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < N_LED; i++) begin
            unique case (bus.mode[2*i +: 2])
                2'b00: lit[i] = 1'b0;
                2'b01: lit[i] = 1'b1;
                2'b10: lit[i] = blink_ph;
                2'b11: lit[i] = (pwm < lvl);
            endcase
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= {N_LED{AL}};
        end else begin
            led_q <= lit ^ {N_LED{AL}};
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: two instances, active-high
// and active-low, driven from the same stimulus.
module tb_led_status_ctrl;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       phase_clr = 1'b0;
    logic [9:0] mode      = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_status_ctrl_if #(.N_LED(5)) ifa ();
    led_status_ctrl_if #(.N_LED(5)) ifb ();

    assign ifa.mode      = mode;
    assign ifa.phase_clr = phase_clr;
    assign ifb.mode      = mode;
    assign ifb.phase_clr = phase_clr;

    led_status_ctrl #(
        .CLK_FREQ(100), .TICK_HZ(10), .N_LED(5),
        .BLINK_MS(2), .PWM_W(3), .ACTIVE_LOW(0)
    ) dut_a (
        .clk50M (clk),
        .reset_n(reset_n),
        .bus    (ifa)
    );

    led_status_ctrl #(
        .CLK_FREQ(100), .TICK_HZ(10), .N_LED(5),
        .BLINK_MS(2), .PWM_W(3), .ACTIVE_LOW(1)
    ) dut_b (
        .clk50M (clk),
        .reset_n(reset_n),
        .bus    (ifb)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves reset released at 1ns after an edge; next edge is edge 1
    task automatic do_reset();
        reset_n   = 1'b0;
        phase_clr = 1'b0;
        step(2);
        chk("rst_led_a", int'(ifa.led), 0);
        chk("rst_led_b", int'(ifb.led), 31);
        chk("rst_tick_a", int'(ifa.tick), 0);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int exp_l [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    initial begin
        int first, nt, bad, bad3, badi, cnt, cntb, w, p;
        logic e;

        // static modes
        mode = '0;
        do_reset();
        mode = 10'b01_0101_0101;
        step(1);
        chk("on_led_a", int'(ifa.led), 31);
        chk("on_led_b", int'(ifb.led), 0);
        mode = '0;
        step(1);
        chk("off_led_a", int'(ifa.led), 0);
        chk("off_led_b", int'(ifb.led), 31);

        // timebase, then async reset while tick is high
        do_reset();
        mode  = 10'b01_0101_0101;
        first = 0;
        nt    = 0;
        bad   = 0;
        for (int k = 1; k <= 1000; k++) begin
            step(1);
            if (ifa.tick) begin
                nt++;
                if (first == 0) first = k;
            end
            if (ifa.tick != (k % 10 == 0)) bad++;
            if (ifb.tick != ifa.tick) bad++;
        end
        chk("tick_first", first, 10);
        chk("tick_count", nt, 100);
        chk("tick_pattern", bad, 0);
        reset_n = 1'b0;
        #1;
        chk("async_tick", int'(ifa.tick), 0);
        chk("async_led_a", int'(ifa.led), 0);
        chk("async_led_b", int'(ifb.led), 31);

        // blink, channel 3 joined late, active-low inverse
        do_reset();
        mode = 10'b00_0000_0010;
        bad  = 0;
        bad3 = 0;
        badi = 0;
        for (int k = 1; k <= 120; k++) begin
            step(1);
            e = (k >= 2) ? 1'(((k - 2) / 20) % 2) : 1'b0;
            if (ifa.led[0] !== e) bad++;
            if (k >= 51 && ifa.led[3] !== e) bad3++;
            if (ifb.led !== ~ifa.led) badi++;
            if (ifa.led[2:1] != 2'b00 || ifa.led[4]) badi++;
            if (k == 21) chk("blink_k21", int'(ifa.led[0]), 0);
            if (k == 22) chk("blink_k22", int'(ifa.led[0]), 1);
            if (k == 42) chk("blink_k42", int'(ifa.led[0]), 0);
            if (k == 62) chk("blink_k62", int'(ifa.led[0]), 1);
            if (k == 50) mode = 10'b00_1000_0010;
        end
        chk("blink_wave", bad, 0);
        chk("blink_ch3", bad3, 0);
        chk("blink_inv", badi, 0);

        // breathe duty per 8-cycle window within each tick interval
        do_reset();
        mode = 10'b00_0000_1100;
        cnt  = 0;
        cntb = 0;
        for (int k = 1; k <= 170; k++) begin
            step(1);
            if (k >= 2) begin
                w = (k - 2) / 10;
                p = (k - 2) % 10;
                if (w <= 16 && p < 8) begin
                    cnt  += int'(ifa.led[1]);
                    cntb += int'(ifb.led[1]);
                end
                if (w <= 16 && p == 7) begin
                    chk($sformatf("duty_w%0d", w), cnt, exp_l[w]);
                    chk($sformatf("dutyb_w%0d", w), cntb, 8 - exp_l[w]);
                    cnt  = 0;
                    cntb = 0;
                end
            end
        end

        // phase_clr mid-blink and coincident with tick
        do_reset();
        mode = 10'b00_0000_1110;
        cnt  = 0;
        for (int k = 1; k <= 80; k++) begin
            step(1);
            if ((k >= 33 && k <= 40) || (k >= 43 && k <= 50) ||
                (k >= 64 && k <= 71))
                cnt += int'(ifa.led[1]);
            if (k == 30) begin
                chk("clr_pre", int'(ifa.led[0]), 1);
                phase_clr = 1'b1;
            end
            if (k == 31) begin
                phase_clr = 1'b0;
                chk("clr_lag", int'(ifa.led[0]), 1);
            end
            if (k == 32) chk("clr_dark", int'(ifa.led[0]), 0);
            if (k == 40) begin
                chk("clr_lvl0", cnt, 0);
                cnt = 0;
            end
            if (k == 50) begin
                chk("clr_lvl1", cnt, 1);
                cnt = 0;
            end
            if (k == 52) chk("clr_k52", int'(ifa.led[0]), 0);
            if (k == 53) chk("clr_rise", int'(ifa.led[0]), 1);
            if (k == 61) begin
                chk("clr_tick_hi", int'(ifa.tick), 1);
                phase_clr = 1'b1;
            end
            if (k == 62) begin
                phase_clr = 1'b0;
                chk("clr_tick_lo", int'(ifa.tick), 0);
            end
            if (k == 71) begin
                chk("clr_nostep", cnt, 0);
                chk("clr_k71_tick", int'(ifa.tick), 0);
            end
            if (k == 72) chk("clr_k72_tick", int'(ifa.tick), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
